// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and op predicates for the RV32M execute unit
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    function automatic logic is_signed_a(input op_e op);
        return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return op == OP_MULH || op == OP_DIV || op == OP_REM;
    endfunction

    function automatic logic is_rem(input op_e op);
        return op == OP_REM || op == OP_REMU;
    endfunction
endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative unsigned restoring divider, one quotient bit per cycle
// Ports: clk, rst (async, active-high), start (load operands and run first iteration),
// flush (abandon), dividend/divisor (unsigned), done (all XLEN bits produced),
// quotient/remainder (unsigned, valid while done).
module muldiv_divider
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] rem_q, quo_q, dvs_q, rem_i, quo_i, dvs_i;
    logic [XLEN:0]   shifted, diff;
    logic [CW-1:0]   cnt;
    logic            run;

    // The start edge already performs the first iteration so that XLEN
    // iterations finish XLEN edges after the start edge.
    always_comb begin
        rem_i   = start ? '0 : rem_q;
        quo_i   = start ? dividend : quo_q;
        dvs_i   = start ? divisor : dvs_q;
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, dvs_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start || (run && cnt != '0)) begin
            rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo_q <= {quo_i[XLEN-2:0], ~diff[XLEN]};
            dvs_q <= dvs_i;
            cnt   <= start ? CW'(XLEN - 1) : cnt - CW'(1);
            run   <= 1'b1;
        end else if (done) begin
            run <= 1'b0;
        end
    end

    assign done      = run && cnt == '0;
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
// Ports: clk, rst (async, active-high); request in_valid/in_ready with in_op (funct3),
// in_a, in_b, in_tag; flush kills the in-flight op; result out_valid/out_ready with
// out_result and out_tag held stable until handshake; busy while not idle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam logic [1:0] MUL_INIT = 2'(MUL_CYCLES - 1);

    state_e            state, state_d;
    op_e               op_in, op_q;
    logic              accept, div_start, div_done, q_neg, r_neg, sa, sb, dz, ov;
    logic [1:0]        mul_cnt;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   mul_sel, mul_tail, a_abs, b_abs, corner, div_q, div_r, div_fix;

    assign op_in     = op_e'(in_op);
    assign in_ready  = state == S_IDLE && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = state == S_DONE;
    assign busy      = state != S_IDLE;

    // Sign-extending to the full product width makes the low 2*XLEN bits of a
    // plain multiply correct for every signed/unsigned operand mix.
    always_comb begin
        sa      = is_signed_a(op_in);
        sb      = is_signed_b(op_in);
        a_ext   = {{XLEN{sa & in_a[XLEN-1]}}, in_a};
        b_ext   = {{XLEN{sb & in_b[XLEN-1]}}, in_b};
        prod    = a_ext * b_ext;
        mul_sel = op_in == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        dz      = in_b == '0;
        ov      = sa && in_a == {1'b1, {(XLEN-1){1'b0}}} && &in_b;
        corner  = dz ? (is_rem(op_in) ? in_a : '1) : (is_rem(op_in) ? '0 : in_a);
        a_abs   = (sa & in_a[XLEN-1]) ? -in_a : in_a;
        b_abs   = (sb & in_b[XLEN-1]) ? -in_b : in_b;
        div_fix = is_rem(op_q) ? (r_neg ? -div_r : div_r) : (q_neg ? -div_q : div_q);
    end

    generate
        if (MUL_CYCLES == 1) begin : g_nopipe
            assign mul_tail = mul_sel;
        end else begin : g_pipe
            logic [XLEN-1:0] pipe [MUL_CYCLES-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_CYCLES - 1; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= mul_sel;
                    for (int i = 1; i < MUL_CYCLES - 1; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign mul_tail = pipe[MUL_CYCLES-2];
        end
    endgenerate

    always_comb begin
        state_d   = state;
        div_start = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    if (!in_op[2]) begin
                        state_d = MUL_CYCLES == 1 ? S_DONE : S_MUL;
                    end else if (dz || ov) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_DIV;
                        div_start = 1'b1;
                    end
                end
                S_MUL:   state_d = mul_cnt == 2'd1 ? S_DONE : S_MUL;
                S_DIV:   state_d = div_done ? S_DONE : S_DIV;
                S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_MUL;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            mul_cnt    <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                out_tag <= in_tag;
                q_neg   <= sa & (in_a[XLEN-1] ^ in_b[XLEN-1]);
                r_neg   <= sa & in_a[XLEN-1];
                mul_cnt <= MUL_INIT;
            end else if (state == S_MUL) begin
                mul_cnt <= mul_cnt - 2'd1;
            end
            if (accept && !in_op[2] && MUL_CYCLES == 1) out_result <= mul_sel;
            else if (accept && in_op[2] && (dz || ov))  out_result <= corner;
            else if (state == S_MUL && state_d == S_DONE) out_result <= mul_tail;
            else if (state == S_DIV && state_d == S_DONE) out_result <= div_fix;
        end
    end

    muldiv_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .flush     (flush),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed check of muldiv_unit plus multi-cycle corner sequences
module tb_muldiv_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0, busy;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0, out_result;
    logic [4:0]  in_tag = '0, out_tag;
    int          n_vec = 0, n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        int          lat;
    } vec_t;
    vec_t vt[20];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_CYCLES(2), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, scrambles the inputs after the accept edge, counts edges
    // (accept edge = 1) until out_valid, then completes the handshake.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res,
                         output logic [4:0] rtag, output int lat);
        int w = 0;
        while (!in_ready && w < 50) begin step(); w++; end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: in_ready still 0 after %0d cycles", w);
        end
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        step();
        in_valid = 1'b0; in_op = ~op; in_a = ~a; in_b = ~b; in_tag = ~tag;
        lat = 1;
        while (!out_valid && lat < 100) begin step(); lat++; end
        res = out_result;
        rtag = out_tag;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  t;
        int          l;
        vt[0]  = '{3'b000, 32'hFFFFFFF9, 32'd6, 5'd7, 32'hFFFFFFD6, 2};
        vt[1]  = '{3'b001, 32'hFFFFFFF9, 32'd6, 5'd7, 32'hFFFFFFFF, 2};
        vt[2]  = '{3'b010, 32'hFFFFFFF9, 32'd6, 5'd7, 32'hFFFFFFFF, 2};
        vt[3]  = '{3'b011, 32'hFFFFFFF9, 32'd6, 5'd7, 32'h00000005, 2};
        vt[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2, 5'd1, 32'hFFFFFFFD, 33};
        vt[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFF, 33};
        vt[6]  = '{3'b101, 32'hFFFFFFF9, 32'd2, 5'd3, 32'h7FFFFFFC, 33};
        vt[7]  = '{3'b111, 32'hFFFFFFF9, 32'd2, 5'd4, 32'h00000001, 33};
        vt[8]  = '{3'b100, 32'd5, 32'd0, 5'd5, 32'hFFFFFFFF, 1};
        vt[9]  = '{3'b111, 32'd5, 32'd0, 5'd6, 32'h00000005, 1};
        vt[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 1};
        vt[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h00000000, 1};
        vt[12] = '{3'b100, 32'hFFFFFF9C, 32'd7, 5'd10, 32'hFFFFFFF2, 33};
        vt[13] = '{3'b110, 32'hFFFFFF9C, 32'd7, 5'd11, 32'hFFFFFFFE, 33};
        vt[14] = '{3'b100, 32'd100, 32'hFFFFFFF9, 5'd12, 32'hFFFFFFF2, 33};
        vt[15] = '{3'b110, 32'd100, 32'hFFFFFFF9, 5'd13, 32'h00000002, 33};
        vt[16] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFE, 2};
        vt[17] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'h00000000, 2};
        vt[18] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'hFFFFFFFF, 2};
        vt[19] = '{3'b111, 32'd100, 32'd7, 5'd17, 32'h00000002, 33};

        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", {27'b0, out_tag}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, r, t, l);
            chk($sformatf("vec%0d_result", i), r, vt[i].res);
            chk($sformatf("vec%0d_tag", i), {27'b0, t}, {27'b0, vt[i].tag});
            chk($sformatf("vec%0d_latency", i), l, vt[i].lat);
        end

        // Backpressure on a MULHU result, with a competing request held valid.
        in_valid = 1'b1; in_op = 3'b011; in_a = 32'hFFFFFFF9; in_b = 32'd6; in_tag = 5'd9;
        step();
        in_op = 3'b000; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd10;
        step();
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_result", out_result, 32'h00000005);
            chk("bp_tag", {27'b0, out_tag}, 32'd9);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_hs_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        out_ready = 1'b0;
        chk("bp_after_hs_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_after_hs_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_next_accepted", {31'b0, busy}, 32'd1);
        l = 1;
        while (!out_valid && l < 100) begin step(); l++; end
        chk("bp_next_latency", l, 32'd2);
        chk("bp_next_result", out_result, 32'd12);
        chk("bp_next_tag", {27'b0, out_tag}, 32'd10);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush 10 cycles into a DIV while a different op is offered.
        in_valid = 1'b1; in_op = 3'b100; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd3;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1; in_valid = 1'b1; in_op = 3'b000; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd11;
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        l = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) l++;
            step();
        end
        chk("flush_no_activity", l, 32'd0);
        do_op(3'b000, 32'd3, 32'd4, 5'd12, r, t, l);
        chk("flush_next_result", r, 32'd12);
        chk("flush_next_tag", {27'b0, t}, 32'd12);

        // Asynchronous reset in the middle of a divide.
        in_valid = 1'b1; in_op = 3'b101; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd4;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_out_result", out_result, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("arst_release_in_ready", {31'b0, in_ready}, 32'd1);
        do_op(3'b101, 32'd100, 32'd7, 5'd21, r, t, l);
        chk("arst_divu_result", r, 32'd14);
        chk("arst_divu_tag", {27'b0, t}, 32'd21);
        chk("arst_divu_latency", l, 32'd33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle RV32M execute unit covering all eight M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the single-cycle ALU in the EX stage. The pipeline hands it operands over a valid/ready handshake and stalls until the result handshake completes. It adds a retimable multi-cycle multiplier, an iterative divider with RISC-V-defined corner cases, tag passthrough, and flush.

## Interface
- XLEN, 32: operand/result width; even, ≥ 8
- MUL_CYCLES, 2: multiply latency in cycles; 1..4
- TAG_W, 5: width of the destination tag passed through unchanged
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  3  operation, funct3 encoding
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- in_tag  in  TAG_W  destination tag
- flush  in  1  kill any in-flight operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of the request that produced the result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset enters IDLE.
- in_ready = (state==IDLE) & ~flush & ~rst.
- A request is accepted on an edge where in_valid & in_ready. At that edge the unit latches in_op, in_tag and the operand data.
- MUL-class ops (op[2]=0):
  - Operands are extended to XLEN+1 bits before multiplying. a is sign-extended for MULH and MULHSU. b is sign-extended for MULH only.
  - MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
  - The state counts down MUL_CYCLES-1 cycles in MUL, then goes to DONE.
- DIV-class ops (op[2]=1):
  - Divide-by-zero (b==0) goes straight to DONE. The quotient is all-ones; the remainder is a.
  - Signed overflow (DIV/REM, a==1<<(XLEN-1), b==all-ones) goes straight to DONE. The quotient is a; the remainder is 0.
  - Otherwise the unit loads |a| and |b| (raw values for DIVU/REMU) and runs XLEN restoring iterations in DIV, one quotient bit per cycle.
  - It then takes one sign-fix edge into DONE:
    - Quotient is negated when the operand signs differ (signed ops).
    - Remainder takes the sign of a.
- DONE: out_valid=1. out_result and out_tag are held stable until out_valid & out_ready, which returns the FSM to IDLE.
- Flush has highest priority. From any state the FSM goes to IDLE on the next edge and the result is discarded. out_valid is 0 after that edge. No accept occurs on a flush cycle.
- Reset (async, any time): state=IDLE, counters 0.
  - Registered outputs: out_valid=0, out_result=0, out_tag=0.
  - Combinational outputs: busy=0, in_ready=0 while rst is high.

## Timing
- Latency is L edges from the accept edge to out_valid=1:
  - MUL-class: L=MUL_CYCLES
  - DIV normal: L=XLEN+1 (XLEN iterations plus sign fix)
  - Divide-by-zero or overflow: L=1
- At most one operation is in flight.
- Earliest next accept is the edge after the result handshake edge. in_ready is 0 through DONE, including the handshake cycle.
- out_valid may stay high indefinitely under backpressure. Result and tag must not change while it does.
- in_op, in_a, in_b and in_tag are sampled only at the accept edge. Changes after that edge are ignored.

## Structure
- muldiv_pkg holds:
  - op enum: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111
  - state enum
  - helper functions for the op predicates is_signed_a, is_signed_b and is_rem
- Sub-module muldiv_divider: iterative restoring core.
  - Inputs: start, dividend, divisor, flush.
  - Outputs: done, quotient, remainder (unsigned).
- The multiplier is a single registered product with MUL_CYCLES-1 trailing retiming registers. It is inline in muldiv_unit.

## Test plan
- MUL/MULH/MULHSU/MULHU with a=0xFFFFFFF9, b=6, tag=7:
  - Results: 0xFFFFFFD6, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000005.
  - out_tag=7; out_valid exactly 2 edges after accept.
- DIV/REM/DIVU/REMU with a=0xFFFFFFF9, b=2:
  - Results: 0xFFFFFFFD, 0xFFFFFFFF, 0x7FFFFFFC, 0x00000001.
  - Latency 33 edges.
- Corner cases:
  - DIV 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
  - All four have latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a MULHU result.
  - Result and tag stay stable; in_ready stays 0.
  - The next request is accepted the edge after out_ready=1.
- Flush: pulse flush 10 cycles into a DIV; in the same cycle, assert in_valid with a different op.
  - No out_valid appears and that op is not accepted.
  - The next request, MUL 3×4, returns 12 with the correct tag.
- Reset: assert rst asynchronously mid-divide.
  - out_valid, out_result and busy go 0 immediately.
  - After release, in_ready=1 and a fresh DIVU 100/7 returns 14.
